// File: rtl/perf_monitor_pkg.sv
// perf_pkg: shared types and constants for the pipeline performance monitor.
//   state_t  : monitor FSM state (IDLE / RUN / HALTED)
//   SEL_*    : rd_sel_i encoding for the counter read port
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_STALL  = 2'd1;
  localparam logic [1:0] SEL_FLUSH  = 2'd2;
  localparam logic [1:0] SEL_RETIRE = 2'd3;

endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: bundle of the CPU event strobes, the counter read port and
// the optional flush-trace port of perf_monitor.
//   master modport : the CPU/host side (drives events, select, trace pop)
//   slave modport  : the monitor side (drives counts, status, trace head)
// Parameter CNT_W sets the width of rd_data_o.
// The trace signals exist only when PERF_TRACE_EN is defined.
// `state` is a debug copy of the monitor FSM state.
interface perf_monitor_if #(
  parameter int CNT_W = 32
);
  import perf_pkg::*;

  logic             start_i;
  logic             stall_i;
  logic             jump_i;
  logic             branch_i;
  logic             flush_i;
  logic [31:0]      pc_i;
  logic             retire_i;
  logic [1:0]       rd_sel_i;
  logic [CNT_W-1:0] rd_data_o;
  logic             running_o;
  logic             halt_o;
  state_t           state;
`ifdef PERF_TRACE_EN
  logic             trace_pop_i;
  logic             trace_valid_o;
  logic [31:0]      trace_pc_o;
  logic             trace_ovf_o;

  modport master (
    output start_i, stall_i, jump_i, branch_i, flush_i, pc_i, retire_i,
           rd_sel_i, trace_pop_i,
    input  rd_data_o, running_o, halt_o, state,
           trace_valid_o, trace_pc_o, trace_ovf_o
  );
  modport slave (
    input  start_i, stall_i, jump_i, branch_i, flush_i, pc_i, retire_i,
           rd_sel_i, trace_pop_i,
    output rd_data_o, running_o, halt_o, state,
           trace_valid_o, trace_pc_o, trace_ovf_o
  );
`else
  modport master (
    output start_i, stall_i, jump_i, branch_i, flush_i, pc_i, retire_i,
           rd_sel_i,
    input  rd_data_o, running_o, halt_o, state
  );
  modport slave (
    input  start_i, stall_i, jump_i, branch_i, flush_i, pc_i, retire_i,
           rd_sel_i,
    output rd_data_o, running_o, halt_o, state
  );
`endif
endinterface

// File: rtl/perf_trace_fifo.sv
// perf_trace_fifo: synchronous first-word-fall-through FIFO with a sticky
// overflow flag, used to record the PC of each counted flush.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i/data_i: write request and data
//   pop_i        : remove head (ignored when empty)
//   valid_o      : FIFO non-empty; data_o is the head entry
//   ovf_o        : sticky, set when a push is dropped because the FIFO is full
// DEPTH must be a power of two so the pointers wrap naturally.
module perf_trace_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         ovf_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          pop_eff;
  logic          push_eff;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_eff = pop_i & ~empty;
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign push_eff = push_i & (~full | pop_eff);

  always_ff @(posedge clk_i) begin
    if (push_eff) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_eff) - (AW+1)'(pop_eff);
      if (push_i & ~push_eff) ovf_o <= 1'b1;
    end
  end

  assign valid_o = ~empty;
  assign data_o  = mem[rd_ptr];

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: cycle-accurate pipeline event monitor.
// Counts cycles, qualified stalls, flushes and retired instructions from the
// first edge with start_i high, for CYCLE_LIMIT cycles, then freezes and
// raises halt_o. Counters saturate at all-ones.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : event strobes, counter select/read, status, trace port
// Parameters: CNT_W (counter width), CYCLE_LIMIT (1 .. 2^CNT_W-1),
//             TRACE_DEPTH (power of two, trace FIFO entries).
// Build option: define PERF_TRACE_EN to add the flush-trace FIFO
// (perf_trace_fifo) and its trace_* signals; counter behaviour is unchanged.
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int TRACE_DEPTH = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  perf_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(CYCLE_LIMIT);

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] cyc_inc;
  logic             counting;
  logic             stall_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // The start edge itself is counted cycle 1, so IDLE with start_i counts.
  assign counting  = (state == RUN) || ((state == IDLE) && bus.start_i);
  // A stall that coincides with a jump/branch is a control redirect, not a
  // data hazard, and is not counted.
  assign stall_evt = bus.stall_i & ~bus.jump_i & ~bus.branch_i;
  assign cyc_inc   = sat_inc(cyc_cnt);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      bus.running_o <= 1'b0;
      bus.halt_o    <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (counting) begin
            if (cyc_inc == LIMIT) begin
              state         <= HALTED;
              bus.running_o <= 1'b0;
              bus.halt_o    <= 1'b1;
            end else begin
              state         <= RUN;
              bus.running_o <= 1'b1;
              bus.halt_o    <= 1'b0;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state         <= IDLE;
          bus.running_o <= 1'b0;
          bus.halt_o    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else if (counting) begin
      cyc_cnt <= cyc_inc;
      if (stall_evt)    stall_cnt  <= sat_inc(stall_cnt);
      if (bus.flush_i)  flush_cnt  <= sat_inc(flush_cnt);
      if (bus.retire_i) retire_cnt <= sat_inc(retire_cnt);
    end
  end

  // Read port samples the pre-update registers, i.e. the value left by the
  // previous edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rd_data_o <= '0;
    end else begin
      case (bus.rd_sel_i)
        SEL_CYCLE:  bus.rd_data_o <= cyc_cnt;
        SEL_STALL:  bus.rd_data_o <= stall_cnt;
        SEL_FLUSH:  bus.rd_data_o <= flush_cnt;
        default:    bus.rd_data_o <= retire_cnt;
      endcase
    end
  end

  assign bus.state = state;

`ifdef PERF_TRACE_EN
  perf_trace_fifo #(
    .W     (32),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (counting & bus.flush_i),
    .data_i  (bus.pc_i),
    .pop_i   (bus.trace_pop_i),
    .valid_o (bus.trace_valid_o),
    .data_o  (bus.trace_pc_o),
    .ovf_o   (bus.trace_ovf_o)
  );
`else
  logic unused_pc;
  assign unused_pc = ^bus.pc_i;
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: drives three perf_monitor instances with identical stimulus
//   u_a : CNT_W=32, CYCLE_LIMIT=30 (default configuration)
//   u_b : CNT_W=32, CYCLE_LIMIT=5  (short run, final-cycle events)
//   u_c : CNT_W=4,  CYCLE_LIMIT=15 (narrow counters, saturation)
// Expected values come from the recorded stimulus history: a counter equals
// the number of qualifying events in the window of counted cycles, clipped to
// the counter range. With PERF_TRACE_EN the trace FIFO of u_a is checked
// against a queue.
module tb_perf_monitor;
  import perf_pkg::*;

  localparam int LIM_A = 30, W_A = 32;
  localparam int LIM_B = 5,  W_B = 32;
  localparam int LIM_C = 15, W_C = 4;
  localparam int TDEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perf_monitor_if #(.CNT_W(W_A)) if_a ();
  perf_monitor_if #(.CNT_W(W_B)) if_b ();
  perf_monitor_if #(.CNT_W(W_C)) if_c ();

  perf_monitor #(.CNT_W(W_A), .CYCLE_LIMIT(LIM_A), .TRACE_DEPTH(TDEPTH))
    u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  perf_monitor #(.CNT_W(W_B), .CYCLE_LIMIT(LIM_B), .TRACE_DEPTH(TDEPTH))
    u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  perf_monitor #(.CNT_W(W_C), .CYCLE_LIMIT(LIM_C), .TRACE_DEPTH(TDEPTH))
    u_c (.clk_i(clk), .rst_i(rst), .bus(if_c));

  // ---------------- reference model ----------------
  typedef struct {
    bit          start, stall, jump, branch, flush, retire, pop;
    logic [31:0] pc;
    logic [1:0]  sel;
  } cyc_t;

  cyc_t        hist[$];   // hist[i] = inputs sampled at edge i+1 since reset
  logic [31:0] tq[$];     // expected trace FIFO contents
  bit          t_ovf;
  int          tests = 0;
  int          fails = 0;

  function automatic int start_idx();
    for (int j = 0; j < hist.size(); j++)
      if (hist[j].start) return j + 1;
    return 0;
  endfunction

  // Counted window is cycles s .. s+lim-1 where s is the first start cycle.
  function automatic bit counted(int k, int lim);
    int s = start_idx();
    return (s != 0) && (k >= s) && (k <= s + lim - 1);
  endfunction

  function automatic longint cnt_after(int k, int sel, int lim, int w);
    longint c = 0;
    longint mx = (longint'(1) << w) - 1;
    for (int j = 1; j <= k; j++) begin
      if (counted(j, lim)) begin
        case (sel)
          0: c++;
          1: if (hist[j-1].stall && !hist[j-1].jump && !hist[j-1].branch) c++;
          2: if (hist[j-1].flush) c++;
          default: if (hist[j-1].retire) c++;
        endcase
      end
    end
    return (c > mx) ? mx : c;
  endfunction

  // 0 = idle, 1 = run, 2 = halted after edge k
  function automatic int state_after(int k, int lim);
    int s = start_idx();
    if (s == 0 || k < s) return 0;
    if (k >= s + lim - 1) return 2;
    return 1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input logic [63:0] rd, input logic run,
                          input logic hlt, input logic [1:0] st, input int lim, input int w);
    int k = hist.size();
    int es = state_after(k, lim);
    longint er = (k == 0) ? 0 : cnt_after(k - 1, int'(hist[k-1].sel), lim, w);
    chk({nm, "_rd_data"}, rd, 64'(er));
    chk({nm, "_running"}, 64'(run), 64'(es == 1));
    chk({nm, "_halt"}, 64'(hlt), 64'(es == 2));
    chk({nm, "_state"}, 64'(st), 64'(es));
  endtask

  task automatic check_all();
    chk_inst("a", 64'(if_a.rd_data_o), if_a.running_o, if_a.halt_o, if_a.state, LIM_A, W_A);
    chk_inst("b", 64'(if_b.rd_data_o), if_b.running_o, if_b.halt_o, if_b.state, LIM_B, W_B);
    chk_inst("c", 64'(if_c.rd_data_o), if_c.running_o, if_c.halt_o, if_c.state, LIM_C, W_C);
`ifdef PERF_TRACE_EN
    chk("a_trace_valid", 64'(if_a.trace_valid_o), 64'(tq.size() > 0));
    chk("a_trace_ovf", 64'(if_a.trace_ovf_o), 64'(t_ovf));
    if (tq.size() > 0) chk("a_trace_pc", 64'(if_a.trace_pc_o), 64'(tq[0]));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic drive(input cyc_t c);
    if_a.start_i = c.start;  if_b.start_i = c.start;  if_c.start_i = c.start;
    if_a.stall_i = c.stall;  if_b.stall_i = c.stall;  if_c.stall_i = c.stall;
    if_a.jump_i  = c.jump;   if_b.jump_i  = c.jump;   if_c.jump_i  = c.jump;
    if_a.branch_i = c.branch; if_b.branch_i = c.branch; if_c.branch_i = c.branch;
    if_a.flush_i = c.flush;  if_b.flush_i = c.flush;  if_c.flush_i = c.flush;
    if_a.retire_i = c.retire; if_b.retire_i = c.retire; if_c.retire_i = c.retire;
    if_a.pc_i = c.pc;        if_b.pc_i = c.pc;        if_c.pc_i = c.pc;
    if_a.rd_sel_i = c.sel;   if_b.rd_sel_i = c.sel;   if_c.rd_sel_i = c.sel;
`ifdef PERF_TRACE_EN
    if_a.trace_pop_i = c.pop; if_b.trace_pop_i = c.pop; if_c.trace_pop_i = c.pop;
`endif
  endtask

  function automatic cyc_t mk(bit st, bit stl, bit jmp, bit brn, bit fls, bit ret,
                              logic [31:0] pc, logic [1:0] sel, bit pop);
    cyc_t c;
    c.start = st; c.stall = stl; c.jump = jmp; c.branch = brn;
    c.flush = fls; c.retire = ret; c.pc = pc; c.sel = sel; c.pop = pop;
    return c;
  endfunction

  function automatic cyc_t rnd_cyc(bit st);
    return mk(st, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC,
              2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
  endfunction

  task automatic cycle(input cyc_t c);
    int k;
    int pre;
    bit pe;
    drive(c);
    hist.push_back(c);
    k = hist.size();
    // FIFO model: pop acts on the pre-edge contents, a push into a full FIFO
    // survives only if the head leaves on the same edge.
    pre = tq.size();
    pe  = c.pop && (pre > 0);
    if (pe) void'(tq.pop_front());
    if (c.flush && counted(k, LIM_A)) begin
      if (pre < TDEPTH || pe) tq.push_back(c.pc);
      else t_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input cyc_t c);
    drive(c);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    tq.delete();
    t_ovf = 1'b0;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc_t idle_c = mk(0, 0, 0, 0, 0, 0, 32'h0, SEL_CYCLE, 0);
    cyc_t run_c  = mk(1, 0, 0, 0, 0, 0, 32'h0, SEL_CYCLE, 0);
    t_ovf = 1'b0;
    drive(idle_c);
    @(posedge clk);
    #1;
    do_reset(idle_c);

    // Cycle limit: start held, no events; halt on edge 30, cycles freeze at 30.
    for (int i = 1; i <= 35; i++) begin
      cycle(run_c);
      if (i == 29) chk("limit_halt_e29", 64'(if_a.halt_o), 64'd0);
      if (i == 30) chk("limit_halt_e30", 64'(if_a.halt_o), 64'd1);
      if (i == 35) chk("limit_cycles", 64'(if_a.rd_data_o), 64'd30);
    end

    // Stall qualification: 4 stalls, one with jump, one with branch.
    do_reset(idle_c);
    cycle(mk(1, 1, 0, 0, 0, 0, 0, SEL_STALL, 0));
    cycle(mk(1, 1, 1, 0, 0, 0, 0, SEL_STALL, 0));
    cycle(mk(1, 1, 0, 1, 0, 0, 0, SEL_STALL, 0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, SEL_STALL, 0));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, SEL_STALL, 0));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, SEL_STALL, 0));
    chk("stall_qual", 64'(if_a.rd_data_o), 64'd2);

    // Final-cycle events on the short instance.
    do_reset(idle_c);
    for (int i = 1; i <= 4; i++) cycle(run_c);
    cycle(mk(1, 0, 0, 0, 1, 1, 32'h100, SEL_CYCLE, 0));
    chk("final_halt_b", 64'(if_b.halt_o), 64'd1);
    cycle(mk(1, 0, 0, 0, 1, 0, 32'h104, SEL_FLUSH, 0));
    cycle(mk(1, 0, 0, 0, 0, 0, 0, SEL_FLUSH, 0));
    chk("final_flush_b", 64'(if_b.rd_data_o), 64'd1);
    cycle(mk(1, 0, 0, 0, 0, 0, 0, SEL_RETIRE, 0));
    chk("final_retire_b", 64'(if_b.rd_data_o), 64'd1);

    // Saturation on the 4-bit instance, then reset mid-run of instance a.
    do_reset(idle_c);
    for (int i = 1; i <= 20; i++) cycle(mk(1, 0, 0, 0, 0, 1, 0, SEL_RETIRE, 0));
    chk("sat_retire_c", 64'(if_c.rd_data_o), 64'd15);
    chk("midrun_running_a", 64'(if_a.running_o), 64'd1);
    do_reset(mk(1, 1, 0, 0, 1, 1, 32'h40, SEL_RETIRE, 0));
    for (int s = 0; s < 4; s++) begin
      cycle(mk(0, 0, 0, 0, 0, 0, 0, 2'(s), 0));
      chk("rst_zero_a", 64'(if_a.rd_data_o), 64'd0);
      chk("rst_running_a", 64'(if_a.running_o), 64'd0);
    end

`ifdef PERF_TRACE_EN
    // Nine flushes into an 8-entry FIFO: last one dropped, overflow sticky.
    do_reset(idle_c);
    for (int i = 1; i <= 9; i++) cycle(mk(1, 0, 0, 0, 1, 0, 32'(4 * i), SEL_FLUSH, 0));
    chk("trace_ovf", 64'(if_a.trace_ovf_o), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("trace_head", 64'(if_a.trace_pc_o), 64'(4 * i));
      cycle(mk(1, 0, 0, 0, 0, 0, 0, SEL_FLUSH, 1));
    end
    chk("trace_empty", 64'(if_a.trace_valid_o), 64'd0);
`endif

    // Randomized runs: random start delay, random events/selects/pops,
    // and resets that often land mid-run.
    for (int r = 0; r < 8; r++) begin
      int dly = $urandom_range(0, 4);
      int len = $urandom_range(10, 45);
      do_reset(rnd_cyc($urandom_range(0, 1) == 1));
      for (int i = 0; i < len; i++) begin
        bit st = (i >= dly) ? ($urandom_range(0, 3) != 0) : 1'b0;
        cycle(rnd_cyc(st));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Cycle-accurate pipeline event monitor attached to the CPU core. It consumes the per-cycle hazard-unit stall, control-unit jump/branch, IF/ID flush and writeback-retire strobes. It accumulates saturating cycle, stall, flush and retired-instruction counts from the first cycle after `start_i` rises, and freezes the counts after a fixed cycle budget. It raises `halt_o` at that point, so simulation or a host can stop the run and read the counters through a registered select port.

## Interface
Parameters:
- `CNT_W`, 32: width of every counter and of `rd_data_o`.
- `CYCLE_LIMIT`, 30: number of RUN cycles counted before halting; legal range 1 to 2^CNT_W−1.
- `TRACE_DEPTH`, 8: flush-trace FIFO entries, power of two; used only with `PERF_TRACE_EN`.

Ports:
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: CPU start level, same signal that drives the core.
- `stall_i`, in, 1: hazard-detection stall request to the IF/ID stage.
- `jump_i`, in, 1: control unit jump decode.
- `branch_i`, in, 1: control unit taken-branch decode.
- `flush_i`, in, 1: IF/ID flush.
- `pc_i`, in, 32: current PC register output.
- `retire_i`, in, 1: instruction valid in WB (non-bubble).
- `rd_sel_i`, in, 2: counter select: 0 cycles, 1 stalls, 2 flushes, 3 retired.
- `rd_data_o`, out, CNT_W: selected counter, registered.
- `running_o`, out, 1: state is RUN.
- `halt_o`, out, 1: state is HALTED.
- `trace_pop_i`, in, 1: only with `PERF_TRACE_EN`. Pops the FIFO head.
- `trace_valid_o`, out, 1: only with `PERF_TRACE_EN`. FIFO is non-empty.
- `trace_pc_o`, out, 32: only with `PERF_TRACE_EN`. Head entry, first-word fall-through.
- `trace_ovf_o`, out, 1: only with `PERF_TRACE_EN`. Sticky, set when a push is dropped.

## Operation
- States are IDLE, RUN and HALTED. Reset enters IDLE.
- IDLE to RUN: on an edge with `start_i`=1. Events present in that cycle are counted, and that cycle is cycle 1.
- RUN:
  - The cycle counter increments by 1 every edge.
  - The stall counter increments when `stall_i` & !`jump_i` & !`branch_i`.
  - The flush counter increments when `flush_i` is high.
  - The retired counter increments when `retire_i` is high.
  - All counters are independent and may increment on the same edge.
- RUN to HALTED: on the edge where the cycle counter's next value equals `CYCLE_LIMIT`. Events in that final cycle are still counted.
- HALTED: counters are frozen, and `start_i` and all events are ignored. Only `rst_i` exits this state.
- `start_i` dropping during RUN has no effect; the monitor counts until the limit.
- Counters saturate at all-ones and never wrap.
- `rd_data_o` samples the counter selected by `rd_sel_i` every edge in every state. It reflects the post-update counter value from the previous edge.
- Reset mid-RUN: all counters, state and FIFO clear on that edge, and nothing is counted in the reset cycle.

## Timing
- Reset values: `rd_data_o`=0, `running_o`=0, `halt_o`=0, `trace_valid_o`=0, `trace_ovf_o`=0. `trace_pc_o` is don't-care while invalid.
- `running_o` and `halt_o` are registered state decodes. They change on the same edge as the state.
- Read latency: `rd_sel_i` is applied in cycle N and `rd_data_o` is valid after edge N.
- Counter update to visible on `rd_data_o`: 2 edges.
- With `CYCLE_LIMIT`=30 and `start_i` set before the first edge, `halt_o` rises on edge 30.
- FIFO rules:
  - Push happens in RUN on `flush_i`.
  - Pop happens on `trace_pop_i` & `trace_valid_o`.
  - Pop when empty is ignored.
  - Push when full is dropped and sets `trace_ovf_o`.
  - Simultaneous push and pop when full: both take effect, the count is unchanged, and no overflow is flagged.
  - Simultaneous push and pop when empty: the push is stored and the pop is ignored.
  - Pointers wrap modulo `TRACE_DEPTH`.

## Configuration
- `PERF_TRACE_EN` defined: the flush-trace FIFO and its four ports exist. The PC captured for each counted flush is stored.
- `PERF_TRACE_EN` undefined: the trace ports and FIFO are absent. Counter behaviour is identical in both builds.

## Structure
- Package `perf_pkg`: the state enum (IDLE/RUN/HALTED) and the `rd_sel_i` encoding constants (SEL_CYCLE=0, SEL_STALL=1, SEL_FLUSH=2, SEL_RETIRE=3).
- Sub-module `perf_trace_fifo`: a parameterized synchronous FWFT FIFO with an overflow flag. It is instantiated only under `PERF_TRACE_EN`.

## Test plan
- Cycle limit: reset, then hold `start_i`=1 with no events for 35 cycles. `halt_o` rises on edge 30, and SEL_CYCLE reads 30 and then stays at 30.
- Stall qualification: apply `stall_i`=1 for 4 RUN cycles, with `jump_i`=1 in one of them and `branch_i`=1 in another. SEL_STALL reads 2.
- Final-cycle events: set `CYCLE_LIMIT`=5 and pulse `flush_i` and `retire_i` in cycle 5 only. SEL_FLUSH=1 and SEL_RETIRE=1; a further flush in cycle 6 is not counted.
- Saturation and reset: set `CNT_W`=4 and `CYCLE_LIMIT`=15, and hold `retire_i`=1 for 20 cycles. SEL_RETIRE=15; asserting `rst_i` mid-run then gives 0 on all selects and `running_o`=0.
- Trace FIFO (`PERF_TRACE_EN`): apply 9 flushes with PCs 0x4, 0x8, …, 0x24 without popping. `trace_ovf_o`=1, and pops return 0x4 through 0x20 in order, then `trace_valid_o`=0.
